// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Used by instr_mem_boot_loader (optional checksum stage: BOOT_CHECKSUM_EN).
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_full marks the
// byte that completes a word.
module byte_word_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [IDX_W-1:0] idx;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            idx  <= '0;
            word <= '0;
        end else if (byte_en) begin
            word[8*idx +: 8] <= byte_in;
            idx              <= idx + IDX_W'(1);
        end
    end

    assign word_full = byte_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_boot_loader.sv
// Boot loader: receives a length header plus byte stream, writes packed words to
// instruction memory and holds the CPU until done. Define BOOT_CHECKSUM_EN for the XOR check byte.
module instr_mem_boot_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [LEN_W:0] DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  words_inc;
    logic [ADDR_W-1:0] waddr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] word;
    logic              word_full;
    logic              accept;
    logic              accept_data;
    logic              start_ok;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    // byte_ready depends on state only, keeping it out of the packer feedback path.
    assign byte_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                         (state == DATA)   || (state == CHECK);
    assign accept      = byte_valid && byte_ready;
    assign accept_data = accept && (state == DATA);
    assign start_ok    = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign hdr_len     = LEN_W'({byte_in, len_q[7:0]});
    assign words_inc   = words_loaded + LEN_W'(1);

    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .byte_en   (accept_data),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    // NOTE: next state gets its default before the case so no path infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
            LEN_LO:          if (byte_valid) state_nx = LEN_HI;
            LEN_HI: begin
                if (byte_valid) begin
                    if (hdr_len == '0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_nx = CHECK;
`else
                        state_nx = DONE;
`endif
                    end else if ({1'b0, hdr_len} > DEPTH) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA:            if (word_full) state_nx = WRITE;
            WRITE: begin
                if (words_inc == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = DATA;
                end
            end
            CHECK: begin
`ifdef BOOT_CHECKSUM_EN
                if (byte_valid) state_nx = (byte_in == csum_q) ? DONE : ERR;
`else
                state_nx = IDLE;
`endif
            end
            default:         state_nx = IDLE;
        endcase
    end

    // NOTE: only control and packing state is reset; instruction memory keeps whatever was written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            len_q        <= '0;
            words_loaded <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state <= state_nx;
            if (start_ok) words_loaded <= '0;
            if (accept && (state == LEN_LO)) len_q[7:0] <= byte_in;
            if (accept && (state == LEN_HI)) len_q <= hdr_len;
            if (state == WRITE) begin
                words_loaded <= words_inc;
                waddr_q      <= words_loaded[ADDR_W-1:0];
                wdata_q      <= word;
            end
`ifdef BOOT_CHECKSUM_EN
            if (start_ok)         csum_q <= '0;
            else if (accept_data) csum_q <= csum_q ^ byte_in;
`endif
        end
    end

    // Write port shows the live word during WRITE and holds it afterwards.
    assign imem_we    = (state == WRITE);
    assign imem_waddr = imem_we ? words_loaded[ADDR_W-1:0] : waddr_q;
    assign imem_wdata = imem_we ? word : wdata_q;
    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign cpu_hold   = (state != DONE);

endmodule

// File: tb/tb_instr_mem_boot_loader.sv
// Self-checking bench for instr_mem_boot_loader: directed and randomized loads
// compared against a word-list model built from the byte stream.
module tb_instr_mem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  words_loaded;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  cyc = 0;
    int  total_cnt = 0;
    int  pass_cnt = 0;

    instr_mem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) got_q.push_back('{addr: imem_waddr, data: imem_wdata, cyc: cyc});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 = valid held high, 1 = random idle cycles, 2 = idle cycle before every byte
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        if (gap == 2 || (gap == 1 && $urandom_range(0, 1) == 1)) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total_cnt++;
        if (byte_ready !== 1'b1) begin
            $display("FAIL byte_accept: byte_ready=%b after %0d cycles, required 1", byte_ready, waited);
        end else begin
            pass_cnt++;
            tick();
        end
    endtask

    task automatic pulse_start();
        byte_valid = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Drives one complete load and builds the expected write list from the byte list.
    task automatic do_load(input logic [15:0] len, input logic [7:0] data[$], input int gap,
                           input int start_at, input logic [7:0] csum_flip);
        logic [7:0] csum;
        got_q.delete();
        exp_q.delete();
        pulse_start();
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        csum = 8'h00;
        for (int i = 0; i < data.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(data[i], gap);
            csum = csum ^ data[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(csum ^ csum_flip, gap);
`endif
        byte_valid = 1'b0;
        for (int w = 0; w < data.size() / 4; w++) begin
            exp_q.push_back('{addr: ADDR_W'(w),
                              data: {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]},
                              cyc: 0});
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({cpu_hold, done, error, byte_ready, imem_we} !== 5'b10000) begin
            $display("FAIL reset_flags: {hold,done,err,ready,we}=%b, required 10000",
                     {cpu_hold, done, error, byte_ready, imem_we});
        end else pass_cnt++;
        total_cnt++;
        if (imem_waddr !== '0 || imem_wdata !== '0) begin
            $display("FAIL reset_wport: waddr=%h wdata=%h, required 0", imem_waddr, imem_wdata);
        end else pass_cnt++;
        total_cnt++;
        if (words_loaded !== '0) begin
            $display("FAIL reset_count: words_loaded=%0d, required 0", words_loaded);
        end else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [63:0] v;
        logic [7:0]  d[$];
        v = 64'h8B000421_D2800013;
        for (int i = 0; i < 8; i++) d.push_back(v[8*i +: 8]);
        do_load(16'd2, d, 0, -1, 8'h00);
        total_cnt++;
        if (got_q.size() !== 2) $display("FAIL dir_nwrites: got %0d writes, required 2", got_q.size());
        else pass_cnt++;
        if (got_q.size() >= 2) begin
            total_cnt++;
            if (got_q[0].addr !== 8'd0 || got_q[0].data !== 32'hD2800013)
                $display("FAIL dir_w0: addr=%h data=%h, required 00/D2800013", got_q[0].addr, got_q[0].data);
            else pass_cnt++;
            total_cnt++;
            if (got_q[1].addr !== 8'd1 || got_q[1].data !== 32'h8B000421)
                $display("FAIL dir_w1: addr=%h data=%h, required 01/8B000421", got_q[1].addr, got_q[1].data);
            else pass_cnt++;
            total_cnt++;
            if (got_q[1].cyc - got_q[0].cyc !== 5)
                $display("FAIL dir_spacing: %0d cycles between writes, required 5", got_q[1].cyc - got_q[0].cyc);
            else pass_cnt++;
        end
        total_cnt++;
        if (words_loaded !== 16'd2 || done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL dir_status: words=%0d done=%b hold=%b err=%b, required 2/1/0/0",
                     words_loaded, done, cpu_hold, error);
        else pass_cnt++;
        total_cnt++;
        if (imem_we !== 1'b0 || imem_waddr !== 8'd1 || imem_wdata !== 32'h8B000421)
            $display("FAIL dir_hold: we=%b addr=%h data=%h, required 0/01/8B000421", imem_we, imem_waddr, imem_wdata);
        else pass_cnt++;
        // A byte offered while idle in DONE must not be consumed.
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (byte_ready !== 1'b0 || done !== 1'b1 || words_loaded !== 16'd2)
            $display("FAIL dir_idle_byte: ready=%b done=%b words=%0d, required 0/1/2", byte_ready, done, words_loaded);
        else pass_cnt++;
        byte_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        got_q.delete();
        pulse_start();
        total_cnt++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== '0)
            $display("FAIL zero_restart: done=%b hold=%b words=%0d, required 0/1/0", done, cpu_hold, words_loaded);
        else pass_cnt++;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        total_cnt++;
        if (done !== 1'b0 || byte_ready !== 1'b1)
            $display("FAIL zero_wait_csum: done=%b ready=%b, required 0/1", done, byte_ready);
        else pass_cnt++;
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
`endif
        total_cnt++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL zero_done: done=%b hold=%b err=%b, required 1/0/0", done, cpu_hold, error);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (got_q.size() !== 0 || words_loaded !== '0)
            $display("FAIL zero_nowrite: writes=%0d words=%0d, required 0/0", got_q.size(), words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_too_long();
        got_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        byte_in = 8'hAB;
        repeat (3) tick();
        total_cnt++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL long_err: err=%b hold=%b ready=%b done=%b, required 1/1/0/0",
                     error, cpu_hold, byte_ready, done);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() !== 0 || words_loaded !== '0)
            $display("FAIL long_nowrite: writes=%0d words=%0d, required 0/0", got_q.size(), words_loaded);
        else pass_cnt++;
        byte_valid = 1'b0;
    endtask

    task automatic test_gappy_start();
        logic [7:0] d[$];
        d.push_back(8'hAA);
        d.push_back(8'hBB);
        d.push_back(8'hCC);
        d.push_back(8'hDD);
        do_load(16'd1, d, 2, 2, 8'h00);
        total_cnt++;
        if (got_q.size() !== 1) $display("FAIL gap_nwrites: got %0d writes, required 1", got_q.size());
        else pass_cnt++;
        if (got_q.size() >= 1) begin
            total_cnt++;
            if (got_q[0].addr !== 8'd0 || got_q[0].data !== 32'hDDCCBBAA)
                $display("FAIL gap_w0: addr=%h data=%h, required 00/DDCCBBAA", got_q[0].addr, got_q[0].data);
            else pass_cnt++;
        end
        total_cnt++;
        if (done !== 1'b1 || words_loaded !== 16'd1)
            $display("FAIL gap_status: done=%b words=%0d, required 1/1", done, words_loaded);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d[$];
        got_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        byte_valid = 1'b0;
        reset      = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        d.push_back(8'h11);
        d.push_back(8'h22);
        d.push_back(8'h33);
        d.push_back(8'h44);
        do_load(16'd1, d, 0, -1, 8'h00);
        total_cnt++;
        if (got_q.size() !== 1 || got_q[0].addr !== 8'd0 || got_q[0].data !== 32'h44332211)
            $display("FAIL rst_reload: writes=%0d first=%h, required 1 write 00/44332211",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
        else pass_cnt++;
    endtask

    // Compares captured writes against the model list; used after every modelled load.
    task automatic test_load(input logic [15:0] len, input int gap, input int start_at, input string tag);
        logic [7:0] d[$];
        for (int i = 0; i < 4 * int'(len); i++) d.push_back(8'($urandom));
        do_load(len, d, gap, start_at, 8'h00);
        total_cnt++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s_nwrites: got %0d writes, required %0d", tag, got_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data)
                $display("FAIL %s_w%0d: addr=%h data=%h, required %h/%h", tag, i,
                         got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            else pass_cnt++;
        end
        total_cnt++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== len)
            $display("FAIL %s_status: done=%b err=%b words=%0d, required 1/0/%0d", tag, done, error, words_loaded, len);
        else pass_cnt++;
    endtask

    task automatic test_full_depth();
        test_load(16'd256, 0, -1, "full");
        total_cnt++;
        if (imem_waddr !== 8'hFF)
            $display("FAIL full_lastaddr: waddr=%h, required FF", imem_waddr);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int len;
            int sa;
            len = $urandom_range(1, 6);
            sa  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * len - 1) : -1;
            test_load(16'(len), 1, sa, "rand");
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] d[$];
        d.push_back(8'hAA);
        d.push_back(8'hBB);
        d.push_back(8'hCC);
        d.push_back(8'hDD);
        do_load(16'd1, d, 0, -1, 8'h00);
        total_cnt++;
        if (done !== 1'b1 || error !== 1'b0)
            $display("FAIL csum_good: done=%b err=%b, required 1/0", done, error);
        else pass_cnt++;
        do_load(16'd1, d, 0, -1, 8'h01);
        total_cnt++;
        if (done !== 1'b0 || error !== 1'b1 || cpu_hold !== 1'b1)
            $display("FAIL csum_bad: done=%b err=%b hold=%b, required 0/1/1", done, error, cpu_hold);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() !== 1) $display("FAIL csum_bad_nwrites: got %0d writes, required 1", got_q.size());
        else pass_cnt++;
    endtask
`endif

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_directed();
        test_zero_len();
        test_too_long();
        test_gappy_start();
        test_reset_mid_load();
        test_full_depth();
        test_random();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
